// File: rtl/maxpool2x2_stream_if.sv
// rtl/maxpool2x2_stream_if.sv - pixel stream interface for maxpool2x2_stream
interface maxpool2x2_stream_if #(
  parameter int DW = 8
);
  logic [DW-1:0] pixel_in;
  logic          pixel_valid;
  logic [DW-1:0] pixel_out;
  logic          pixel_out_valid;
  logic          frame_done;

  // Upstream producer / downstream consumer side
  modport master (
    output pixel_in,
    output pixel_valid,
    input  pixel_out,
    input  pixel_out_valid,
    input  frame_done
  );

  // Pooling block side
  modport slave (
    input  pixel_in,
    input  pixel_valid,
    output pixel_out,
    output pixel_out_valid,
    output frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 pooling (max, or average with MAXPOOL_AVG_EN)
module maxpool2x2_stream #(
  parameter int W  = 4,
  parameter int H  = 4,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst,
  maxpool2x2_stream_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int NP = W / 2;
  localparam int LI = (NP > 1) ? $clog2(NP) : 1;
`ifdef MAXPOOL_AVG_EN
  localparam int LW = DW + 1;   // pair sums need one extra bit
`else
  localparam int LW = DW;
`endif
  localparam bit H_ODD = (H % 2) == 1;

  typedef enum logic [1:0] {
    ST_EVEN = 2'd0,
    ST_ODD  = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   hold_q;
  logic [LW-1:0]   lbuf_q [NP];
  logic [DW-1:0]   out_q;
  logic            out_valid_q;
  logic            frame_done_q;

  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            pair_ok;
  logic [LI-1:0]   lbuf_idx;
  logic [LW-1:0]   lbuf_rd;
  logic [LW-1:0]   pair_val;
  logic [DW-1:0]   out_val;
  logic            lbuf_we;
  logic            out_en;

  assign accept   = bus.pixel_valid;
  assign col_last = (col_q == CW'(W - 1));
  assign row_last = (row_q == RW'(H - 1));
  // With odd W the last column is even, so an odd column always closes a full pair
  assign pair_ok  = accept & col_q[0];
  assign lbuf_idx = LI'(col_q >> 1);
  assign lbuf_rd  = lbuf_q[lbuf_idx];

`ifdef MAXPOOL_AVG_EN
  logic [DW+1:0] quad_sum;
  assign pair_val = {1'b0, hold_q} + {1'b0, bus.pixel_in};
  assign quad_sum = {1'b0, lbuf_rd} + {1'b0, pair_val};
  assign out_val  = DW'(quad_sum >> 2);
`else
  assign pair_val = (hold_q >= bus.pixel_in) ? hold_q : bus.pixel_in;
  assign out_val  = (lbuf_rd >= pair_val) ? lbuf_rd : pair_val;
`endif

  // Column/row position of the next accepted beat
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Row-type state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EVEN;
    else      state_q <= state_d;
  end

  // Row-type transitions happen only when a row wraps
  always_comb begin
    state_d = state_q;
    if (accept && col_last) begin
      case (state_q)
        ST_EVEN: state_d = ST_ODD;
        ST_ODD:  state_d = (H_ODD && (row_q == RW'(H - 2))) ? ST_SKIP : ST_EVEN;
        default: state_d = ST_EVEN;
      endcase
    end
  end

  // Per-state datapath enables: even rows fill the line buffer, odd rows emit
  always_comb begin
    lbuf_we = 1'b0;
    out_en  = 1'b0;
    case (state_q)
      ST_EVEN: lbuf_we = pair_ok;
      ST_ODD:  out_en  = pair_ok;
      default: ;
    endcase
  end

  // Counters, previous-pixel hold and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_en;
      frame_done_q <= accept & col_last & row_last;
      if (accept) hold_q <= bus.pixel_in;
      if (out_en) out_q  <= out_val;
    end
  end

  // Line buffer of even-row partial results; always written before it is read
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[lbuf_idx] <= pair_val;
  end

  assign bus.pixel_out       = out_q;
  assign bus.pixel_out_valid = out_valid_q;
  assign bus.frame_done      = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - directed self-checking bench for maxpool2x2_stream
module tb_maxpool2x2_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.DW(8)) if4 ();
  maxpool2x2_stream_if #(.DW(8)) if3 ();
  maxpool2x2_stream_if #(.DW(8)) if2 ();

  maxpool2x2_stream #(.W(4), .H(4), .DW(8)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
  maxpool2x2_stream #(.W(3), .H(3), .DW(8)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  maxpool2x2_stream #(.W(2), .H(2), .DW(8)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;
  int last_out [5];

`ifdef MAXPOOL_AVG_EN
  int e_fwd [4] = '{3, 5, 11, 13};
  int e_rev [4] = '{13, 11, 5, 3};
  int e3  = 52;
  int e2a = 2;
`else
  int e_fwd [4] = '{6, 8, 14, 16};
  int e_rev [4] = '{16, 14, 8, 6};
  int e3  = 100;
  int e2a = 5;
`endif
  int e2b = 255;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic [7:0] p, input logic v);
    case (u)
      4: begin if4.pixel_in = p; if4.pixel_valid = v; end
      3: begin if3.pixel_in = p; if3.pixel_valid = v; end
      default: begin if2.pixel_in = p; if2.pixel_valid = v; end
    endcase
  endtask

  task automatic sample(input int u, output logic [7:0] d, output logic v, output logic fd);
    case (u)
      4: begin d = if4.pixel_out; v = if4.pixel_out_valid; fd = if4.frame_done; end
      3: begin d = if3.pixel_out; v = if3.pixel_out_valid; fd = if3.frame_done; end
      default: begin d = if2.pixel_out; v = if2.pixel_out_valid; fd = if2.frame_done; end
    endcase
  endtask

  task automatic beat(input int u, input logic [7:0] p, input bit ev, input int ed,
                      input bit efd, input string tag);
    logic [7:0] d;
    logic       v;
    logic       fd;
    drive(u, p, 1'b1);
    @(posedge clk);
    #1;
    drive(u, p, 1'b0);
    sample(u, d, v, fd);
    chk({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
    chk({tag, "_done"}, {31'd0, fd}, {31'd0, efd});
    if (ev) last_out[u] = ed;
    chk({tag, "_data"}, {24'd0, d}, last_out[u]);
  endtask

  task automatic idle(input int u, input int n, input string tag);
    logic [7:0] d;
    logic       v;
    logic       fd;
    repeat (n) begin
      @(posedge clk);
      #1;
      sample(u, d, v, fd);
      chk({tag, "_idle_valid"}, {31'd0, v}, 32'd0);
      chk({tag, "_idle_done"}, {31'd0, fd}, 32'd0);
    end
  endtask

  task automatic frame4(input bit rev, input int gap, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int r = i / 4;
      int c = i % 4;
      int k = (r / 2) * 2 + c / 2;
      bit ev = (r % 2 == 1) && (c % 2 == 1);
      int ed = rev ? e_rev[k] : e_fwd[k];
      logic [7:0] p = rev ? 8'(16 - i) : 8'(i + 1);
      beat(4, p, ev, ed, (i == 15), $sformatf("%s_%0d", tag, i));
      if (gap > 0) idle(4, gap, tag);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       v;
    logic       fd;
    int         px3 [9] = '{10, 50, 10, 50, 100, 50, 10, 50, 10};
    int         px2 [4] = '{1, 2, 3, 5};

    rst = 1'b0;
    drive(4, 8'd0, 1'b0);
    drive(3, 8'd0, 1'b0);
    drive(2, 8'd0, 1'b0);
    for (int u = 0; u < 5; u++) last_out[u] = 0;
    repeat (3) @(posedge clk);
    #1;

    sample(4, d, v, fd);
    chk("rst4_data", {24'd0, d}, 32'd0);
    chk("rst4_valid", {31'd0, v}, 32'd0);
    chk("rst4_done", {31'd0, fd}, 32'd0);
    sample(3, d, v, fd);
    chk("rst3_data", {24'd0, d}, 32'd0);
    chk("rst3_valid", {31'd0, v}, 32'd0);
    sample(2, d, v, fd);
    chk("rst2_data", {24'd0, d}, 32'd0);
    chk("rst2_valid", {31'd0, v}, 32'd0);
    rst = 1'b1;

    idle(4, 2, "pre");
    frame4(1'b0, 0, 16, "basic");
    idle(4, 2, "post_basic");
    frame4(1'b0, 3, 16, "gap");
    idle(4, 2, "post_gap");
    frame4(1'b0, 0, 16, "b2b_a");
    frame4(1'b1, 0, 16, "b2b_b");
    idle(4, 2, "post_b2b");

    frame4(1'b0, 0, 7, "partial");
    #3;
    rst = 1'b0;
    #1;
    sample(4, d, v, fd);
    chk("midrst_data", {24'd0, d}, 32'd0);
    chk("midrst_valid", {31'd0, v}, 32'd0);
    chk("midrst_done", {31'd0, fd}, 32'd0);
    last_out[4] = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(4, 2, "after_rst");
    frame4(1'b0, 0, 16, "restart");
    idle(4, 2, "post_restart");

    for (int i = 0; i < 9; i++)
      beat(3, 8'(px3[i]), (i == 4), e3, (i == 8), $sformatf("odd3_%0d", i));
    idle(3, 2, "post_odd3");

    for (int i = 0; i < 4; i++)
      beat(2, 8'(px2[i]), (i == 3), e2a, (i == 3), $sformatf("w2_%0d", i));
    for (int i = 0; i < 4; i++)
      beat(2, 8'd255, (i == 3), e2b, (i == 3), $sformatf("w2ff_%0d", i));
    idle(2, 2, "post_w2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
